geofence_gen: RTL and testbench

- Parametrised point-in-convex-polygon engine: the successor of the fixed 6-vertex geofence.
- Accepts one frame per query: a target point followed by NV polygon vertices in arbitrary order.
- Sorts the vertices counter-clockwise around vertex 0, then tests the target against every edge with signed cross products.
- Reports inside, outside or on-edge, and adds an input handshake so upstream may stall.

---
 rtl/geofence_gen_if.sv | 23 ++
 rtl/geofence_gen.sv | 215 +++++++++++++++++++++
 tb/tb_geofence_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/geofence_gen_if.sv
// geofence_gen_if: frame-word input handshake and result bundle for geofence_gen.
// The master drives frame words; the slave (geofence_gen) accepts them and reports results.
interface geofence_gen_if #(
  parameter int CW = 10
);
  logic          in_valid;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          in_ready;
  logic          valid;
  logic          is_inside;
  logic          on_edge;

  modport master (
    output in_valid, X, Y,
    input  in_ready, valid, is_inside, on_edge
  );

  modport slave (
    input  in_valid, X, Y,
    output in_ready, valid, is_inside, on_edge
  );
endinterface

// File: rtl/geofence_gen.sv
// geofence_gen: point-in-convex-polygon engine.
// A frame is the target point followed by NV vertices. The vertices are sorted
// counter-clockwise around vertex 0 with one pairwise cross-product compare per
// cycle, then the target is tested against every edge with signed cross products.
// Optional build macro GEOFENCE_EDGE_EXCL_EN: when defined, points on the boundary
// report is_inside=0 (on_edge is unaffected). Timing and ports do not change.
module geofence_gen #(
  parameter int NV = 6,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  geofence_gen_if.slave bus
);

  localparam int IW = $clog2(NV);      // vertex index width
  localparam int WW = $clog2(NV + 1);  // word counter width (0..NV)
  localparam int DW = CW + 1;          // signed coordinate difference width
  localparam int PW = 2 * CW + 2;      // signed cross product width

  localparam logic [WW-1:0] WCNT_ZERO = WW'(0);
  localparam logic [WW-1:0] WCNT_ONE  = WW'(1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(NV);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_TWO   = IW'(2);
  localparam logic [IW-1:0] IDX_ILAST = IW'(NV - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NV - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SORT = 3'd2,
    ST_CAL  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Difference of two unsigned coordinates as a full-range signed value (no wrap).
  function automatic logic signed [DW-1:0] sub_u(input logic [CW-1:0] a,
                                                 input logic [CW-1:0] b);
    logic signed [DW-1:0] ea;
    logic signed [DW-1:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return ea - eb;
  endfunction

  // Cross product ax*by - ay*bx carried at full width so the sign is exact.
  function automatic logic signed [PW-1:0] cross2(input logic signed [DW-1:0] ax,
                                                  input logic signed [DW-1:0] ay,
                                                  input logic signed [DW-1:0] bx,
                                                  input logic signed [DW-1:0] by);
    logic signed [PW-1:0] eax;
    logic signed [PW-1:0] eay;
    logic signed [PW-1:0] ebx;
    logic signed [PW-1:0] eby;
    eax = {{(PW-DW){ax[DW-1]}}, ax};
    eay = {{(PW-DW){ay[DW-1]}}, ay};
    ebx = {{(PW-DW){bx[DW-1]}}, bx};
    eby = {{(PW-DW){by[DW-1]}}, by};
    return (eax * eby) - (eay * ebx);
  endfunction

  state_t          r_state;
  logic [WW-1:0]   r_wcnt;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [IW-1:0]   r_k;
  logic [CW-1:0]   r_vx [NV];
  logic [CW-1:0]   r_vy [NV];
  logic [CW-1:0]   r_tx;
  logic [CW-1:0]   r_ty;
  logic            r_neg;
  logic            r_zero;
  logic            r_in_ready;
  logic            r_valid;
  logic            r_is_inside;
  logic            r_on_edge;

  logic                 w_accept;
  logic [WW-1:0]        w_wm1;
  logic [IW-1:0]        w_kn;
  logic signed [PW-1:0] w_c;
  logic signed [PW-1:0] w_d;
  logic                 w_neg_n;
  logic                 w_zero_n;
  logic                 w_inside_n;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_wm1    = r_wcnt - WCNT_ONE;
  assign w_kn     = (r_k == IDX_LAST) ? IDX_ZERO : (r_k + IDX_ONE);

  // Sort compare: orientation of v[j] relative to v[i] as seen from v[0].
  assign w_c = cross2(sub_u(r_vx[r_i], r_vx[0]), sub_u(r_vy[r_i], r_vy[0]),
                      sub_u(r_vx[r_j], r_vx[0]), sub_u(r_vy[r_j], r_vy[0]));

  // Edge test: side of the target relative to edge v[k] -> v[k+1].
  assign w_d = cross2(sub_u(r_vx[w_kn], r_vx[r_k]), sub_u(r_vy[w_kn], r_vy[r_k]),
                      sub_u(r_tx, r_vx[r_k]),       sub_u(r_ty, r_vy[r_k]));

  assign w_neg_n  = r_neg  | w_d[PW-1];
  assign w_zero_n = r_zero | (w_d == '0);

`ifdef GEOFENCE_EDGE_EXCL_EN
  assign w_inside_n = ~w_neg_n & ~w_zero_n;
`else
  assign w_inside_n = ~w_neg_n;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.valid     = r_valid;
  assign bus.is_inside = r_is_inside;
  assign bus.on_edge   = r_on_edge;

  // Control FSM with frame capture, sort swaps, edge flags and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= WCNT_ZERO;
      r_i         <= IDX_ZERO;
      r_j         <= IDX_ZERO;
      r_k         <= IDX_ZERO;
      r_tx        <= '0;
      r_ty        <= '0;
      r_neg       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_valid     <= 1'b0;
      r_is_inside <= 1'b0;
      r_on_edge   <= 1'b0;
      for (int n = 0; n < NV; n++) begin
        r_vx[n] <= '0;
        r_vy[n] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_READ;
          r_in_ready <= 1'b1;
          r_wcnt     <= WCNT_ZERO;
          r_neg      <= 1'b0;
          r_zero     <= 1'b0;
          r_valid    <= 1'b0;
        end
        ST_READ: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            if (r_wcnt == WCNT_ZERO) begin
              r_tx <= bus.X;
              r_ty <= bus.Y;
            end else begin
              r_vx[w_wm1[IW-1:0]] <= bus.X;
              r_vy[w_wm1[IW-1:0]] <= bus.Y;
            end
            if (r_wcnt == WCNT_LAST) begin
              r_state    <= ST_SORT;
              r_in_ready <= 1'b0;
              r_wcnt     <= WCNT_ZERO;
              r_i        <= IDX_ONE;
              r_j        <= IDX_TWO;
            end else begin
              r_wcnt <= r_wcnt + WCNT_ONE;
            end
          end
        end
        ST_SORT: begin
          // v[j] clockwise of v[i] means it belongs earlier in CCW order.
          if (w_c[PW-1]) begin
            r_vx[r_i] <= r_vx[r_j];
            r_vy[r_i] <= r_vy[r_j];
            r_vx[r_j] <= r_vx[r_i];
            r_vy[r_j] <= r_vy[r_i];
          end
          if (r_j == IDX_LAST) begin
            if (r_i == IDX_ILAST) begin
              r_state <= ST_CAL;
              r_k     <= IDX_ZERO;
            end else begin
              r_i <= r_i + IDX_ONE;
              r_j <= r_i + IDX_TWO;
            end
          end else begin
            r_j <= r_j + IDX_ONE;
          end
        end
        ST_CAL: begin
          r_neg  <= w_neg_n;
          r_zero <= w_zero_n;
          if (r_k == IDX_LAST) begin
            r_state     <= ST_OUT;
            r_valid     <= 1'b1;
            r_is_inside <= w_inside_n;
            r_on_edge   <= ~w_neg_n & w_zero_n;
          end else begin
            r_k <= r_k + IDX_ONE;
          end
        end
        ST_OUT: begin
          r_state    <= ST_READ;
          r_valid    <= 1'b0;
          r_in_ready <= 1'b1;
          r_wcnt     <= WCNT_ZERO;
          r_neg      <= 1'b0;
          r_zero     <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_gen.sv
// tb_geofence_gen: directed self-checking bench for geofence_gen.
// Main instance NV=6/CW=10 on a hexagon; second instance NV=3/CW=12 on a full-range triangle.
// Expected boundary inside value follows GEOFENCE_EDGE_EXCL_EN.
module tb_geofence_gen;

`ifdef GEOFENCE_EDGE_EXCL_EN
  localparam logic EXP_EDGE_INSIDE = 1'b0;
`else
  localparam logic EXP_EDGE_INSIDE = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  geofence_gen_if #(.CW(10)) m();
  geofence_gen #(.NV(6), .CW(10)) dut (.clk(clk), .reset_n(reset_n), .bus(m.slave));

  geofence_gen_if #(.CW(12)) m12();
  geofence_gen #(.NV(3), .CW(12)) dut12 (.clk(clk), .reset_n(reset_n), .bus(m12.slave));

  logic [9:0] px [6] = '{10'd200, 10'd50, 10'd250, 10'd100, 10'd100, 10'd200};
  logic [9:0] py [6] = '{10'd0, 10'd100, 10'd100, 10'd0, 10'd200, 10'd200};

  // Send target plus the hexagon; optional stalls after word indices sa and sb.
  task automatic send_frame(input logic [9:0] tx, input logic [9:0] ty,
                            input int sa, input int la, input int sb, input int lb,
                            output bit ok);
    int n;
    ok = 1'b1;
    for (int w = 0; w <= 6; w++) begin
      m.in_valid = 1'b1;
      if (w == 0) begin
        m.X = tx; m.Y = ty;
      end else begin
        m.X = px[w-1]; m.Y = py[w-1];
      end
      n = 0;
      while (m.in_ready !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (n >= 60) ok = 1'b0;
      @(negedge clk);
      if (w == sa) begin
        m.in_valid = 1'b0;
        repeat (la) @(negedge clk);
      end
      if (w == sb) begin
        m.in_valid = 1'b0;
        repeat (lb) @(negedge clk);
      end
    end
    m.in_valid = 1'b0;
  endtask

  // From the negedge after the final accept (cycle 1), find the cycle valid is seen.
  task automatic wait_result(output int lat, output int rdy_bad);
    bit done;
    lat = 0; rdy_bad = 0; done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (m.in_ready !== 1'b0) rdy_bad++;
      if (m.valid === 1'b1) begin
        lat = c;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    m.in_valid = 1'b0; m.X = '0; m.Y = '0;
    m12.in_valid = 1'b0; m12.X = '0; m12.Y = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m.valid); end
    checks++; if (m.is_inside !== 1'b0) begin errors++; $display("FAIL rst_inside got %b want 0", m.is_inside); end
    checks++; if (m.on_edge !== 1'b0) begin errors++; $display("FAIL rst_on_edge got %b want 0", m.on_edge); end
    checks++; if (m.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", m.in_ready); end
    reset_n = 1'b1;
    #1;
    checks++; if (m.in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", m.in_ready); end
    @(negedge clk);
    checks++; if (m.in_ready !== 1'b1) begin errors++; $display("FAIL read_ready got %b want 1", m.in_ready); end
  endtask

  task automatic test_inside();
    bit ok; int lat; int rb;
    send_frame(10'd150, 10'd100, -1, 0, -1, 0, ok);
    wait_result(lat, rb);
    checks++; if (!ok || lat != 17) begin errors++; $display("FAIL inside_latency got %0d want 17 (words ok %0d)", lat, ok); end
    checks++; if (rb != 0) begin errors++; $display("FAIL inside_ready_busy got %0d high cycles want 0", rb); end
    checks++; if (m.is_inside !== 1'b1) begin errors++; $display("FAIL inside_is_inside got %b want 1", m.is_inside); end
    checks++; if (m.on_edge !== 1'b0) begin errors++; $display("FAIL inside_on_edge got %b want 0", m.on_edge); end
    @(negedge clk);
    checks++; if (m.valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", m.valid); end
    checks++; if (m.is_inside !== 1'b1) begin errors++; $display("FAIL inside_hold got %b want 1", m.is_inside); end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; int rb;
    send_frame(10'd150, 10'd100, -1, 0, -1, 0, ok);
    wait_result(lat, rb);
    checks++; if (!ok || lat != 17 || m.is_inside !== 1'b1) begin errors++; $display("FAIL b2b_first got lat %0d inside %b want 17 1", lat, m.is_inside); end
    // still in OUT: next frame is offered right away and must wait for READ
    send_frame(10'd300, 10'd100, -1, 0, -1, 0, ok);
    wait_result(lat, rb);
    checks++; if (!ok || lat != 17) begin errors++; $display("FAIL outside_latency got %0d want 17", lat); end
    checks++; if (rb != 0) begin errors++; $display("FAIL outside_ready_busy got %0d high cycles want 0", rb); end
    checks++; if (m.is_inside !== 1'b0) begin errors++; $display("FAIL outside_is_inside got %b want 0", m.is_inside); end
    checks++; if (m.on_edge !== 1'b0) begin errors++; $display("FAIL outside_on_edge got %b want 0", m.on_edge); end
  endtask

  task automatic test_edge();
    bit ok; int lat; int rb;
    @(negedge clk);
    send_frame(10'd150, 10'd0, -1, 0, -1, 0, ok);
    wait_result(lat, rb);
    checks++; if (!ok || lat != 17) begin errors++; $display("FAIL edge_latency got %0d want 17", lat); end
    checks++; if (m.on_edge !== 1'b1) begin errors++; $display("FAIL edge_on_edge got %b want 1", m.on_edge); end
    checks++; if (m.is_inside !== EXP_EDGE_INSIDE) begin errors++; $display("FAIL edge_is_inside got %b want %b", m.is_inside, EXP_EDGE_INSIDE); end
  endtask

  task automatic test_stall();
    bit ok; int lat; int rb;
    @(negedge clk);
    send_frame(10'd150, 10'd100, 2, 3, 5, 5, ok);
    wait_result(lat, rb);
    checks++; if (!ok || lat != 17) begin errors++; $display("FAIL stall_latency got %0d want 17", lat); end
    checks++; if (m.is_inside !== 1'b1) begin errors++; $display("FAIL stall_is_inside got %b want 1", m.is_inside); end
    checks++; if (m.on_edge !== 1'b0) begin errors++; $display("FAIL stall_on_edge got %b want 0", m.on_edge); end
  endtask

  task automatic test_reset_mid_sort();
    bit ok; int lat; int rb; int vcnt;
    @(negedge clk);
    // previous result was a boundary frame, so on_edge is 1 going in
    send_frame(10'd150, 10'd0, -1, 0, -1, 0, ok);
    wait_result(lat, rb);
    checks++; if (m.on_edge !== 1'b1) begin errors++; $display("FAIL pre_reset_on_edge got %b want 1", m.on_edge); end
    @(negedge clk);
    send_frame(10'd150, 10'd100, -1, 0, -1, 0, ok);
    repeat (3) @(negedge clk);   // now in SORT cycle 4
    reset_n = 1'b0;
    #1;
    checks++; if (m.valid !== 1'b0 || m.is_inside !== 1'b0 || m.on_edge !== 1'b0 || m.in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got v%b i%b e%b r%b want all 0", m.valid, m.is_inside, m.on_edge, m.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (m.valid === 1'b1) vcnt++;
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL midreset_no_valid got %0d pulses want 0", vcnt); end
    send_frame(10'd150, 10'd100, -1, 0, -1, 0, ok);
    wait_result(lat, rb);
    checks++; if (!ok || lat != 17 || m.is_inside !== 1'b1) begin errors++; $display("FAIL postreset_inside got lat %0d inside %b want 17 1", lat, m.is_inside); end
  endtask

  // Triangle on the CW=12 instance; vertex order given by the caller.
  task automatic tri_frame(input logic [11:0] tx, input logic [11:0] ty,
                           input logic [11:0] ax, input logic [11:0] ay,
                           input logic [11:0] bx, input logic [11:0] by,
                           input logic [11:0] cx, input logic [11:0] cy,
                           output int lat, output logic ins, output logic edg);
    logic [11:0] wx [4];
    logic [11:0] wy [4];
    bit done;
    int n;
    wx[0] = tx; wx[1] = ax; wx[2] = bx; wx[3] = cx;
    wy[0] = ty; wy[1] = ay; wy[2] = by; wy[3] = cy;
    lat = 0;
    for (int w = 0; w < 4; w++) begin
      m12.in_valid = 1'b1; m12.X = wx[w]; m12.Y = wy[w];
      n = 0;
      while (m12.in_ready !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    m12.in_valid = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (m12.valid === 1'b1) begin
        lat = c; done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    ins = m12.is_inside;
    edg = m12.on_edge;
    @(negedge clk);
  endtask

  task automatic test_width_sign();
    int lat; logic ins; logic edg;
    tri_frame(12'd1, 12'd1, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 12'd4095, lat, ins, edg);
    checks++; if (lat != 5) begin errors++; $display("FAIL tri_latency got %0d want 5", lat); end
    checks++; if (ins !== 1'b1 || edg !== 1'b0) begin errors++; $display("FAIL tri_inside got i%b e%b want i1 e0", ins, edg); end
    tri_frame(12'd4095, 12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 12'd4095, lat, ins, edg);
    checks++; if (lat != 5 || ins !== 1'b0 || edg !== 1'b0) begin errors++; $display("FAIL tri_far_outside got lat %0d i%b e%b want 5 i0 e0", lat, ins, edg); end
    // reversed vertex order forces a swap in the sort
    tri_frame(12'd1, 12'd1, 12'd0, 12'd0, 12'd0, 12'd4095, 12'd4095, 12'd0, lat, ins, edg);
    checks++; if (lat != 5 || ins !== 1'b1 || edg !== 1'b0) begin errors++; $display("FAIL tri_swapped got lat %0d i%b e%b want 5 i1 e0", lat, ins, edg); end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_inside();
    test_back_to_back();
    test_edge();
    test_stall();
    test_reset_mid_sort();
    test_width_sign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
